branch_resolver: RTL and testbench

Resolves control-flow instructions in the execute stage. It takes the `{n,z,c,v}` status nibble the ALU produces for the compare subtraction `a - b`, plus the PC, immediate and rs1, and computes three results: the branch decision, the target address and the link address. Results are held in a 2-entry buffer with a valid/ready handshake and drive fetch redirection. A saturating mispredict counter is kept for performance monitoring.

---
 rtl/branch_resolver.sv | 156 +++++++++++++++
 tb/tb_branch_resolver.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// branch_resolver
// Resolves conditional branches, JAL and JALR in the execute stage and queues
// the results in a 2-entry FIFO that drives fetch redirection.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready request handshake (in_ready depends only on occupancy)
//   is_branch/is_jal/is_jalr, funct3, status{n,z,c,v}, pc, imm, rs1,
//   pred_taken        request payload, sampled on the accept edge only
//   flush             empties the buffer and drops a same-cycle request
//   out_valid/out_ready
//                     head-entry handshake
//   taken, target, link, mispredict, illegal
//                     head-entry fields (all zero when empty)
//   perf_mispredicts  saturating count of popped mispredicted entries
module branch_resolver #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         is_branch,
  input  logic         is_jal,
  input  logic         is_jalr,
  input  logic [2:0]   funct3,
  input  logic [3:0]   status,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] imm,
  input  logic [N-1:0] rs1,
  input  logic         pred_taken,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic [N-1:0] target,
  output logic [N-1:0] link,
  output logic         mispredict,
  output logic         illegal,
  output logic [15:0]  perf_mispredicts
);

  logic [N-1:0] w_link;
  logic [N-1:0] w_pc_imm;
  logic [N-1:0] w_rs1_imm;
  logic [N-1:0] w_target;
  logic         w_cond;
  logic         w_reserved;
  logic         w_taken;
  logic         w_illegal;
  logic         w_mispredict;
  logic         w_push;
  logic         w_pop;

  logic [1:0]   r_count;
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [15:0]  r_perf;

  logic         r_taken  [2];
  logic [N-1:0] r_target [2];
  logic [N-1:0] r_link   [2];
  logic         r_mis    [2];
  logic         r_ill    [2];

  assign w_link    = pc + N'(4);
  assign w_pc_imm  = pc + imm;
  assign w_rs1_imm = rs1 + imm;

  // status = {n, z, c, v}; c = 1 means the subtraction borrowed
  always_comb begin
    w_cond     = 1'b0;
    w_reserved = 1'b0;
    case (funct3)
      3'b000:  w_cond = status[2];
      3'b001:  w_cond = ~status[2];
      3'b100:  w_cond = status[3] ^ status[0];
      3'b101:  w_cond = ~(status[3] ^ status[0]);
      3'b110:  w_cond = status[1];
      3'b111:  w_cond = ~status[1];
      default: w_reserved = 1'b1;
    endcase
  end

  // A not-taken entry carries pc+4 so a mispredict redirect only needs target
  always_comb begin
    w_taken  = 1'b0;
    w_target = w_link;
    if (is_branch) begin
      w_taken = w_cond;
      if (w_cond) w_target = w_pc_imm;
    end else if (is_jal) begin
      w_taken  = 1'b1;
      w_target = w_pc_imm;
    end else if (is_jalr) begin
      w_taken  = 1'b1;
      w_target = {w_rs1_imm[N-1:1], 1'b0};
    end
  end

  assign w_illegal    = is_branch & w_reserved;
  assign w_mispredict = w_taken ^ pred_taken;

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A pop coinciding with flush still reaches the consumer, so it is counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf <= '0;
    end else if (w_pop && r_mis[r_rd_ptr] && (r_perf != '1)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  // Storage needs no reset: outputs are gated by occupancy
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_taken[r_wr_ptr]  <= w_taken;
      r_target[r_wr_ptr] <= w_target;
      r_link[r_wr_ptr]   <= w_link;
      r_mis[r_wr_ptr]    <= w_mispredict;
      r_ill[r_wr_ptr]    <= w_illegal;
    end
  end

  assign taken            = out_valid & r_taken[r_rd_ptr];
  assign target           = out_valid ? r_target[r_rd_ptr] : '0;
  assign link             = out_valid ? r_link[r_rd_ptr] : '0;
  assign mispredict       = out_valid & r_mis[r_rd_ptr];
  assign illegal          = out_valid & r_ill[r_rd_ptr];
  assign perf_mispredicts = r_perf;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: expected entries are queued on accept
// and compared when the DUT pops them.
module tb_branch_resolver;
  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         is_branch;
  logic         is_jal;
  logic         is_jalr;
  logic [2:0]   funct3;
  logic [3:0]   status;
  logic [N-1:0] pc;
  logic [N-1:0] imm;
  logic [N-1:0] rs1;
  logic         pred_taken;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic         taken;
  logic [N-1:0] target;
  logic [N-1:0] link;
  logic         mispredict;
  logic         illegal;
  logic [15:0]  perf_mispredicts;

  branch_resolver #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .status(status), .pc(pc), .imm(imm), .rs1(rs1),
    .pred_taken(pred_taken), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .target(target), .link(link),
    .mispredict(mispredict), .illegal(illegal),
    .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         taken;
    logic [N-1:0] target;
    logic [N-1:0] link;
    logic         mis;
    logic         ill;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_perf   = '0;
  logic [15:0] saved_perf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic br, input logic j, input logic jr,
                                 input logic [2:0] f3, input logic [3:0] st,
                                 input logic [N-1:0] p, input logic [N-1:0] im,
                                 input logic [N-1:0] r, input logic pr);
    exp_t e;
    logic n, z, c, v;
    n = st[3]; z = st[2]; c = st[1]; v = st[0];
    e.link  = p + 32'd4;
    e.ill   = 1'b0;
    e.taken = 1'b0;
    if (br) begin
      case (f3)
        3'd0: e.taken = z;
        3'd1: e.taken = !z;
        3'd4: e.taken = n ^ v;
        3'd5: e.taken = !(n ^ v);
        3'd6: e.taken = c;
        3'd7: e.taken = !c;
        default: e.ill = 1'b1;
      endcase
    end else if (j || jr) begin
      e.taken = 1'b1;
    end
    if (jr)           e.target = (r + im) & 32'hFFFF_FFFE;
    else if (e.taken) e.target = p + im;
    else              e.target = p + 32'd4;
    e.mis = e.taken ^ pr;
    return e;
  endfunction

  // Pops are compared at the negedge preceding the popping edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_pop", out_valid, 1'b0);
      end else begin
        mon_e = q.pop_front();
        check("sb_taken",  taken,      mon_e.taken);
        check("sb_target", target,     mon_e.target);
        check("sb_link",   link,       mon_e.link);
        check("sb_mis",    mispredict, mon_e.mis);
        check("sb_ill",    illegal,    mon_e.ill);
        if (mon_e.mis && m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
      end
    end
  end

  task automatic set_req(input logic br, input logic j, input logic jr,
                         input logic [2:0] f3, input logic [3:0] st,
                         input logic [N-1:0] p, input logic [N-1:0] im,
                         input logic [N-1:0] r, input logic pr);
    is_branch = br; is_jal = j; is_jalr = jr; funct3 = f3; status = st;
    pc = p; imm = im; rs1 = r; pred_taken = pr; in_valid = 1'b1;
    cur = model(br, j, jr, f3, st, p, im, r, pr);
  endtask

  task automatic wait_accept();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        if (!flush) q.push_back(cur);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    status   = 4'hX;
    check("accept_timeout", done, 1'b1);
  endtask

  task automatic send(input logic br, input logic j, input logic jr,
                      input logic [2:0] f3, input logic [3:0] st,
                      input logic [N-1:0] p, input logic [N-1:0] im,
                      input logic [N-1:0] r, input logic pr);
    set_req(br, j, jr, f3, st, p, im, r, pr);
    wait_accept();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0 && !out_valid) done = 1'b1;
    end
    check("drain_timeout", done, 1'b1);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    m_perf = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Single entry through an empty buffer, with constants checked at the head
  task automatic one(input string tag, input logic br, input logic j, input logic jr,
                     input logic [2:0] f3, input logic [3:0] st,
                     input logic [N-1:0] p, input logic [N-1:0] im,
                     input logic [N-1:0] r, input logic pr,
                     input logic x_taken, input logic [N-1:0] x_target,
                     input logic [N-1:0] x_link, input logic x_mis, input logic x_ill);
    out_ready = 1'b0;
    send(br, j, jr, f3, st, p, im, r, pr);
    check({tag, "_valid"},  out_valid,  1'b1);
    check({tag, "_taken"},  taken,      x_taken);
    check({tag, "_target"}, target,     x_target);
    check({tag, "_link"},   link,       x_link);
    check({tag, "_mis"},    mispredict, x_mis);
    check({tag, "_ill"},    illegal,    x_ill);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_empty"}, out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    funct3 = '0; status = '0; pc = '0; imm = '0; rs1 = '0; pred_taken = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid",  out_valid,        1'b0);
    check("rst_in_ready",   in_ready,         1'b1);
    check("rst_taken",      taken,            1'b0);
    check("rst_target",     target,           32'h0);
    check("rst_link",       link,             32'h0);
    check("rst_mis",        mispredict,       1'b0);
    check("rst_ill",        illegal,          1'b0);
    check("rst_perf",       perf_mispredicts, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Branch conditions and target/link computation
    one("beq",  1,0,0, 3'b000, 4'b0100, 32'h100, 32'h20, 32'h0, 0, 1, 32'h120, 32'h104, 1, 0);
    one("bne",  1,0,0, 3'b001, 4'b0100, 32'h100, 32'h20, 32'h0, 0, 0, 32'h104, 32'h104, 0, 0);
    one("blt",  1,0,0, 3'b100, 4'b1001, 32'h200, 32'h40, 32'h0, 0, 0, 32'h204, 32'h204, 0, 0);
    one("bge",  1,0,0, 3'b101, 4'b1001, 32'h200, 32'h40, 32'h0, 1, 1, 32'h240, 32'h204, 0, 0);
    one("bltu", 1,0,0, 3'b110, 4'b0010, 32'h200, 32'h40, 32'h0, 0, 1, 32'h240, 32'h204, 1, 0);
    one("bgeu", 1,0,0, 3'b111, 4'b0010, 32'h200, 32'h40, 32'h0, 1, 0, 32'h204, 32'h204, 1, 0);
    one("f010", 1,0,0, 3'b010, 4'b0100, 32'h200, 32'h40, 32'h0, 0, 0, 32'h204, 32'h204, 0, 1);
    one("f011", 1,0,0, 3'b011, 4'b0000, 32'h200, 32'h40, 32'h0, 1, 0, 32'h204, 32'h204, 1, 1);
    one("jal",  0,1,0, 3'b000, 4'b0000, 32'h1000, 32'hFFFF_FFF0, 32'h0, 1, 1, 32'h0FF0, 32'h1004, 0, 0);
    one("jalr", 0,0,1, 3'b000, 4'b0000, 32'h8, 32'h3, 32'hFFFF_FFFF, 0, 1, 32'h2, 32'hC, 1, 0);
    one("none", 0,0,0, 3'b000, 4'b0100, 32'h50, 32'h10, 32'h0, 1, 0, 32'h54, 32'h54, 1, 0);

    // Backpressure: two accepted, third stalls, head stable, in-order drain
    out_ready = 1'b0;
    send(1,0,0, 3'b000, 4'b0100, 32'h300, 32'h8, 32'h0, 1);
    send(0,1,0, 3'b000, 4'b0000, 32'h310, 32'h100, 32'h0, 0);
    set_req(0,0,1, 3'b000, 4'b0000, 32'h320, 32'h4, 32'h4000, 1);
    check("bp_in_ready_full", in_ready, 1'b0);
    check("bp_head_target0",  target, 32'h308);
    @(posedge clk); #1;
    check("bp_in_ready_hold", in_ready, 1'b0);
    check("bp_head_target1",  target, 32'h308);
    check("bp_head_link1",    link,   32'h304);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_back", in_ready, 1'b1);
    check("bp_second_head",   target, 32'h410);
    wait_accept();
    drain();

    // Flush with full buffer plus a same-cycle request
    out_ready = 1'b0;
    send(0,1,0, 3'b000, 4'b0000, 32'h500, 32'h10, 32'h0, 0);
    send(0,1,0, 3'b000, 4'b0000, 32'h504, 32'h10, 32'h0, 0);
    saved_perf = m_perf;
    set_req(0,0,0, 3'b000, 4'b0000, 32'h508, 32'h0, 32'h0, 0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_perf",      perf_mispredicts, saved_perf);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_deliver", out_valid, 1'b0);

    // Mispredict counting and asynchronous reset
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(0,1,0, 3'b000, 4'b0000, 32'h600 + 32'(4*i), 32'h40, 32'h0, 0);
    drain();
    check("perf_three",       perf_mispredicts, 16'd3);
    check("perf_three_model", perf_mispredicts, m_perf);
    out_ready = 1'b0;
    send(1,0,0, 3'b001, 4'b0000, 32'h700, 32'h8, 32'h0, 0);
    check("arst_pre_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_perf",      perf_mispredicts, 16'h0);
    check("arst_in_ready",  in_ready, 1'b1);
    q.delete();
    m_perf = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Saturation: stream mispredicts until the counter pins at its maximum
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 65534; i++) send(0,1,0, 3'b000, 4'b0000, 32'h800, 32'h4, 32'h0, 0);
    drain();
    check("perf_fffe", perf_mispredicts, 16'hFFFE);
    for (int i = 0; i < 3; i++) send(0,1,0, 3'b000, 4'b0000, 32'h900, 32'h4, 32'h0, 0);
    drain();
    check("perf_sat",       perf_mispredicts, 16'hFFFF);
    check("perf_sat_model", perf_mispredicts, m_perf);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
